aimc_sched_rx: RTL and testbench
================================

AIMC_SCHED_RX -- requirements
Module: aimc_sched_rx

Interface
REQ-001 Parameter CQ_DEPTH, default 8: command FIFO depth in entries, power of two, at least 4.
REQ-002 Parameter TQ_DEPTH, default 16: read-tag queue depth in entries, power of two.
REQ-003 Parameter RD_TIMEOUT, default 255: idle cycles allowed while a read is outstanding.
REQ-004 Clock and reset: one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  synchronous active-low reset.
REQ-007 sched_pkt  in  pkt_t  scheduled packet.
REQ-008 sched_cmd  in  cmd_t  command for sched_pkt.
REQ-009 sched_pkt_valid  in  1  sched_pkt/sched_cmd valid.
REQ-010 intf_rdy  out  1  scheduler may launch arbitration.
REQ-011 phy_pkt  out  pkt_t  packet to PHY.
REQ-012 phy_cmd  out  cmd_t  command to PHY.
REQ-013 phy_valid  out  1  PHY slot valid.
REQ-014 phy_rdy  in  1  PHY accepts slot.
REQ-015 phy_rd_valid  in  1  read data return.
REQ-016 phy_rd_data  in  DATA_WIDTH  read data.
REQ-017 phy_rd_err  in  1  return failed CRC.
REQ-018 rd_data_valid  out  1  good read data valid.
REQ-019 rd_data  out  DATA_WIDTH  good read data.
REQ-020 intf_pkt  out  pkt_t  packet being returned to the scheduler.
REQ-021 intf_pkt_retry  out  1  one-cycle retry pulse.
REQ-022 stat  out  3  sticky flags {timeout, orphan_return, overflow}.

Function
REQ-023 Command FIFO: push {sched_pkt, sched_cmd} when sched_pkt_valid; pop on phy_valid && phy_rdy; same-cycle push and pop permitted at any occupancy.
REQ-024 intf_rdy, registered: 1 iff free entries > 2, covering the two-cycle scheduler pipeline after intf_rdy falls.
REQ-025 Push while full: drop the entry, set stat[0], keep FIFO contents unchanged.
REQ-026 phy_valid = FIFO not empty AND NOT (head cmd == RD AND tag queue full); phy_pkt/phy_cmd come combinationally from the FIFO head.
REQ-027 Latency: entry pushed into an empty FIFO appears on phy_valid the next cycle.
REQ-028 On an accepted RD, push the head pkt into the tag queue; accepted NOP1 and other commands push no tag.
REQ-029 phy_rd_valid pops the tag-queue head; with phy_rd_err=0, next cycle rd_data_valid=1 and rd_data=phy_rd_data.
REQ-030 phy_rd_valid with the tag queue empty: ignore the data, set stat[1].
REQ-031 Same-cycle RD issue and return: tag push and pop both occur; occupancy unchanged.
REQ-032 Timeout counter: 8+ bits; clears on every phy_rd_valid or when the tag queue is empty; increments otherwise; on reaching RD_TIMEOUT, sets stat[2] and saturates.
REQ-033 Pointers wrap modulo depth; full/empty are distinguished by an extra pointer MSB.

Reset
REQ-034 While rst=0: FIFOs emptied, counters zero, stat=0, phy_valid=0, rd_data_valid=0, intf_pkt_retry=0, intf_rdy=0, intf_pkt=0.
REQ-035 intf_rdy=1 in the first cycle after reset release.
REQ-036 Reset mid-operation discards outstanding tags; a later return sets stat[1].

Configuration
REQ-037 Macro AIMC_SCHED_RX_RETRY_EN.
REQ-038 Defined: a return with phy_rd_err=1 gives, next cycle, intf_pkt = popped tag pkt, intf_pkt_retry=1 for one cycle, rd_data_valid=0.
REQ-039 Undefined: intf_pkt_retry is tied 0 and intf_pkt is tied 0; an errored return still pops the tag, sets rd_data_valid=1, and passes phy_rd_data through.

Structure
REQ-040 Parameter defaults and a stat bit-index enum go in aimc_lib; pkt_t and cmd_t are reused from aimc_lib.
REQ-041 One sub-module, aimc_sync_fifo (parameterised width/depth, full/empty/count outputs), instantiated for both the command FIFO and the tag queue.

Verification
REQ-042 Reset, then 8 back-to-back pushes with phy_rdy=0 -> intf_rdy falls after the 6th push; the 7th and 8th pushes are accepted; stat=0.
REQ-043 9th push while full -> stat[0]=1; phy output order is still pushes 1..8.
REQ-044 Issue 16 RDs, the 17th cmd is RD -> phy_valid=0 until one return arrives, then the 17th issues.
REQ-045 RD(row 5) issued, return with phy_rd_err=1 and RETRY_EN defined -> intf_pkt.row_addr=5, one-cycle intf_pkt_retry; undefined -> rd_data_valid=1.
REQ-046 phy_rd_valid with no outstanding RD -> stat[1]=1, no rd_data_valid.
REQ-047 One RD issued, no return for 255 cycles -> stat[2]=1 exactly at cycle 255.

Source files
------------

// File: rtl/aimc_lib.sv
`default_nettype none
// ============================================================================
// Module      : aimc_lib (package)
// Description : Shared AIMC types (pkt_t, cmd_t), parameter defaults and the
//               stat bit-index enum for the scheduler receive path.
// Revision    : 1.0 - initial release
// ============================================================================
package aimc_lib;

    localparam int c_cq_depth   = 8;
    localparam int c_tq_depth   = 16;
    localparam int c_rd_timeout = 255;
    localparam int c_data_width = 64;

    typedef enum logic [2:0] {
        CMD_NOP1 = 3'd0,
        CMD_RD   = 3'd1,
        CMD_WR   = 3'd2,
        CMD_ACT  = 3'd3,
        CMD_PRE  = 3'd4,
        CMD_REF  = 3'd5
    } cmd_t;

    typedef struct packed {
        logic [15:0] row_addr;
        logic [3:0]  bank;
        logic [7:0]  col_addr;
    } pkt_t;

    // Bit positions inside the sticky stat vector
    typedef enum logic [1:0] {
        STAT_OVERFLOW = 2'd0,
        STAT_ORPHAN   = 2'd1,
        STAT_TIMEOUT  = 2'd2
    } stat_idx_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aimc_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : aimc_sync_fifo
// Description : Single-clock FIFO, power-of-two depth, extra pointer MSB to
//               tell full from empty. Simultaneous push/pop is accepted at
//               any occupancy, including full.
// Revision    : 1.0 - initial release
// ============================================================================
module aimc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign count = r_wr_ptr - r_rd_ptr;
    assign dout  = r_mem[r_rd_ptr[c_aw-1:0]];

    // A pop in the same cycle frees the slot a push into a full FIFO needs
    assign w_push_ok = push && (!full || pop);
    assign w_pop_ok  = pop && !empty;

    // Pointer update; reset empties the FIFO
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write, no reset needed on the data array
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[c_aw-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/aimc_sched_rx.sv
`default_nettype none
// ============================================================================
// Module      : aimc_sched_rx
// Description : Scheduler-to-PHY command FIFO with read-tag tracking, read
//               data return, read timeout and sticky status flags.
//               Optional build macro AIMC_SCHED_RX_RETRY_EN turns errored
//               read returns into a retry pulse back to the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module aimc_sched_rx
    import aimc_lib::*;
#(
    parameter int CQ_DEPTH   = c_cq_depth,
    parameter int TQ_DEPTH   = c_tq_depth,
    parameter int RD_TIMEOUT = c_rd_timeout,
    parameter int DATA_WIDTH = c_data_width
) (
    input  logic                  clk,
    input  logic                  rst,
    input  pkt_t                  sched_pkt,
    input  cmd_t                  sched_cmd,
    input  logic                  sched_pkt_valid,
    output logic                  intf_rdy,
    output pkt_t                  phy_pkt,
    output cmd_t                  phy_cmd,
    output logic                  phy_valid,
    input  logic                  phy_rdy,
    input  logic                  phy_rd_valid,
    input  logic [DATA_WIDTH-1:0] phy_rd_data,
    input  logic                  phy_rd_err,
    output logic                  rd_data_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output pkt_t                  intf_pkt,
    output logic                  intf_pkt_retry,
    output logic [2:0]            stat
);

    localparam int c_cq_aw = $clog2(CQ_DEPTH);
    localparam int c_tq_aw = $clog2(TQ_DEPTH);
    localparam int c_pkt_w = $bits(pkt_t);
    localparam int c_cmd_w = $bits(cmd_t);
    localparam int c_cq_w  = c_pkt_w + c_cmd_w;
    localparam int c_to_w  = max_int(8, $clog2(RD_TIMEOUT + 1));
    localparam logic [c_to_w-1:0] c_to_max = c_to_w'(RD_TIMEOUT);

    logic [c_cq_w-1:0]  w_cq_dout;
    logic               w_cq_full;
    logic               w_cq_empty;
    logic [c_cq_aw:0]   w_cq_count;
    logic [c_cq_aw:0]   w_cq_count_next;
    logic               w_cq_pop;
    logic               w_cq_push_ok;
    cmd_t               w_head_cmd;

    pkt_t               w_tq_dout;
    logic               w_tq_full;
    logic               w_tq_empty;
    logic [c_tq_aw:0]   w_tq_count;
    logic               w_tq_push;

    logic               w_ret_good;
    logic               w_ret_data_ok;
    logic [c_to_w-1:0]  r_to_cnt;
    logic [c_to_w-1:0]  w_to_cnt_next;
    logic               r_intf_rdy;
    logic               r_rd_data_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [2:0]         r_stat;

    // Command FIFO: {pkt, cmd} per entry, head drives the PHY directly
    aimc_sync_fifo #(.WIDTH(c_cq_w), .DEPTH(CQ_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (sched_pkt_valid),
        .din   ({sched_pkt, sched_cmd}),
        .pop   (w_cq_pop),
        .dout  (w_cq_dout),
        .full  (w_cq_full),
        .empty (w_cq_empty),
        .count (w_cq_count)
    );

    // Tag queue: one pkt per issued RD, popped by each read return
    aimc_sync_fifo #(.WIDTH(c_pkt_w), .DEPTH(TQ_DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_tq_push),
        .din   (phy_pkt),
        .pop   (phy_rd_valid),
        .dout  (w_tq_dout),
        .full  (w_tq_full),
        .empty (w_tq_empty),
        .count (w_tq_count)
    );

    assign phy_pkt    = w_cq_dout[c_cq_w-1 -: c_pkt_w];
    assign w_head_cmd = cmd_t'(w_cq_dout[c_cmd_w-1:0]);
    assign phy_cmd    = w_head_cmd;

    // A RD is held back while there is nowhere to record its tag
    assign phy_valid = rst && !w_cq_empty && !((w_head_cmd == CMD_RD) && w_tq_full);
    assign w_cq_pop  = phy_valid && phy_rdy;
    assign w_tq_push = w_cq_pop && (w_head_cmd == CMD_RD);

    assign w_cq_push_ok    = sched_pkt_valid && (!w_cq_full || w_cq_pop);
    assign w_cq_count_next = w_cq_count + (c_cq_aw + 1)'(w_cq_push_ok)
                                        - (c_cq_aw + 1)'(w_cq_pop);

    assign w_ret_good = phy_rd_valid && !w_tq_empty;

    // Timeout count: idle while empty or on any return, saturates at the limit
    always_comb begin
        w_to_cnt_next = r_to_cnt;
        if (phy_rd_valid || w_tq_empty) begin
            w_to_cnt_next = '0;
        end else if (r_to_cnt != c_to_max) begin
            w_to_cnt_next = r_to_cnt + 1'b1;
        end
    end

    // intf_rdy tracks the post-edge occupancy so two in-flight pushes still fit
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_intf_rdy <= 1'b0;
        end else begin
            r_intf_rdy <= (int'(w_cq_count_next) < (CQ_DEPTH - 2));
        end
    end

    // Timeout counter and sticky status flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_to_cnt <= '0;
            r_stat   <= '0;
        end else begin
            r_to_cnt <= w_to_cnt_next;
            if (sched_pkt_valid && !w_cq_push_ok) r_stat[STAT_OVERFLOW] <= 1'b1;
            if (phy_rd_valid && w_tq_empty)       r_stat[STAT_ORPHAN]   <= 1'b1;
            if (!w_tq_empty && !phy_rd_valid && (w_to_cnt_next == c_to_max))
                r_stat[STAT_TIMEOUT] <= 1'b1;
        end
    end

`ifdef AIMC_SCHED_RX_RETRY_EN
    pkt_t r_intf_pkt;
    logic r_intf_pkt_retry;

    assign w_ret_data_ok = w_ret_good && !phy_rd_err;

    // Errored return: hand the tagged pkt back to the scheduler for one cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_intf_pkt       <= '0;
            r_intf_pkt_retry <= 1'b0;
        end else begin
            r_intf_pkt_retry <= w_ret_good && phy_rd_err;
            if (w_ret_good && phy_rd_err) r_intf_pkt <= w_tq_dout;
        end
    end

    assign intf_pkt       = r_intf_pkt;
    assign intf_pkt_retry = r_intf_pkt_retry;

    logic w_unused_tq;
    assign w_unused_tq = ^w_tq_count;
`else
    // Without retry the CRC flag and the tagged pkt have no consumer
    assign w_ret_data_ok  = w_ret_good;
    assign intf_pkt       = '0;
    assign intf_pkt_retry = 1'b0;

    logic w_unused_tq;
    assign w_unused_tq = ^{w_tq_count, w_tq_dout, phy_rd_err};
`endif

    // Read data return, one cycle after phy_rd_valid
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_data_valid <= 1'b0;
            r_rd_data       <= '0;
        end else begin
            r_rd_data_valid <= w_ret_data_ok;
            if (w_ret_good) r_rd_data <= phy_rd_data;
        end
    end

    assign intf_rdy      = r_intf_rdy;
    assign rd_data_valid = r_rd_data_valid;
    assign rd_data       = r_rd_data;
    assign stat          = r_stat;

endmodule
`default_nettype wire

// File: tb/tb_aimc_sched_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_aimc_sched_rx
// Description : Directed self-checking bench for aimc_sched_rx: reset state,
//               FIFO fill/overflow/order, tag-queue back-pressure, errored
//               return, orphan return, read timeout and mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aimc_sched_rx;
    import aimc_lib::*;

    logic        clk;
    logic        rst;
    pkt_t        sched_pkt;
    cmd_t        sched_cmd;
    logic        sched_pkt_valid;
    logic        intf_rdy;
    pkt_t        phy_pkt;
    cmd_t        phy_cmd;
    logic        phy_valid;
    logic        phy_rdy;
    logic        phy_rd_valid;
    logic [63:0] phy_rd_data;
    logic        phy_rd_err;
    logic        rd_data_valid;
    logic [63:0] rd_data;
    pkt_t        intf_pkt;
    logic        intf_pkt_retry;
    logic [2:0]  stat;

    int n_tests = 0;
    int n_fail  = 0;

    aimc_sched_rx u_dut (
        .clk             (clk),
        .rst             (rst),
        .sched_pkt       (sched_pkt),
        .sched_cmd       (sched_cmd),
        .sched_pkt_valid (sched_pkt_valid),
        .intf_rdy        (intf_rdy),
        .phy_pkt         (phy_pkt),
        .phy_cmd         (phy_cmd),
        .phy_valid       (phy_valid),
        .phy_rdy         (phy_rdy),
        .phy_rd_valid    (phy_rd_valid),
        .phy_rd_data     (phy_rd_data),
        .phy_rd_err      (phy_rd_err),
        .rd_data_valid   (rd_data_valid),
        .rd_data         (rd_data),
        .intf_pkt        (intf_pkt),
        .intf_pkt_retry  (intf_pkt_retry),
        .stat            (stat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_push(input logic v, input logic [15:0] row, input cmd_t c);
        sched_pkt_valid    = v;
        sched_pkt          = '0;
        sched_pkt.row_addr = row;
        sched_pkt.col_addr = row[7:0] ^ 8'h5A;
        sched_cmd          = c;
    endtask

    initial begin
        rst          = 1'b0;
        phy_rdy      = 1'b0;
        phy_rd_valid = 1'b0;
        phy_rd_data  = '0;
        phy_rd_err   = 1'b0;
        set_push(1'b0, 16'd0, CMD_NOP1);

        // Reset state
        repeat (3) tick();
        chk("rst_phy_valid", 64'(phy_valid), 64'd0);
        chk("rst_intf_rdy", 64'(intf_rdy), 64'd0);
        chk("rst_stat", 64'(stat), 64'd0);
        chk("rst_rd_data_valid", 64'(rd_data_valid), 64'd0);
        chk("rst_retry", 64'(intf_pkt_retry), 64'd0);
        chk("rst_intf_pkt", 64'(intf_pkt), 64'd0);

        rst = 1'b1;
        tick();
        chk("rel_intf_rdy", 64'(intf_rdy), 64'd1);

        // Eight pushes with PHY stalled; intf_rdy drops once two slots remain
        for (int k = 1; k <= 8; k++) begin
            set_push(1'b1, 16'(k), CMD_WR);
            tick();
            chk($sformatf("fill_intf_rdy_%0d", k), 64'(intf_rdy), (k <= 5) ? 64'd1 : 64'd0);
            if (k == 1) begin
                chk("fill_first_valid", 64'(phy_valid), 64'd1);
                chk("fill_first_row", 64'(phy_pkt.row_addr), 64'd1);
            end
        end
        chk("fill_stat", 64'(stat), 64'd0);

        // Ninth push is dropped
        set_push(1'b1, 16'd9, CMD_WR);
        tick();
        set_push(1'b0, 16'd0, CMD_NOP1);
        chk("ovf_stat", 64'(stat), 64'd1);

        // Drain: order must be 1..8
        phy_rdy = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("drain_valid_%0d", k), 64'(phy_valid), 64'd1);
            chk($sformatf("drain_row_%0d", k), 64'(phy_pkt.row_addr), 64'(k));
            tick();
        end
        chk("drain_empty", 64'(phy_valid), 64'd0);

        // 17 RDs: tag queue fills at 16, 17th waits for a return
        for (int i = 0; i <= 16; i++) begin
            set_push(1'b1, 16'(100 + i), CMD_RD);
            tick();
        end
        set_push(1'b0, 16'd0, CMD_NOP1);
        tick();
        tick();
        chk("tq_full_blocks", 64'(phy_valid), 64'd0);
        chk("tq_full_head", 64'(phy_pkt.row_addr), 64'd116);
        phy_rd_valid = 1'b1;
        phy_rd_data  = 64'hDEAD_BEEF_0000_0001;
        tick();
        phy_rd_valid = 1'b0;
        chk("tq_ret_valid", 64'(rd_data_valid), 64'd1);
        chk("tq_ret_data", rd_data, 64'hDEAD_BEEF_0000_0001);
        chk("tq_unblock", 64'(phy_valid), 64'd1);
        tick();
        chk("tq_17th_issued", 64'(phy_valid), 64'd0);
        for (int i = 0; i < 16; i++) begin
            phy_rd_valid = 1'b1;
            phy_rd_data  = 64'(1000 + i);
            tick();
            chk($sformatf("tq_drain_data_%0d", i), rd_data, 64'(1000 + i));
        end
        phy_rd_valid = 1'b0;
        tick();
        chk("tq_drain_done", 64'(rd_data_valid), 64'd0);
        chk("tq_stat", 64'(stat), 64'd1);

        // RD row 5 returned with CRC error
        set_push(1'b1, 16'd5, CMD_RD);
        tick();
        set_push(1'b0, 16'd0, CMD_NOP1);
        tick();
        phy_rd_valid = 1'b1;
        phy_rd_err   = 1'b1;
        phy_rd_data  = 64'h0000_0000_0000_ABCD;
        tick();
        phy_rd_valid = 1'b0;
        phy_rd_err   = 1'b0;
`ifdef AIMC_SCHED_RX_RETRY_EN
        chk("err_intf_row", 64'(intf_pkt.row_addr), 64'd5);
        chk("err_retry", 64'(intf_pkt_retry), 64'd1);
        chk("err_no_data", 64'(rd_data_valid), 64'd0);
        tick();
        chk("err_retry_pulse", 64'(intf_pkt_retry), 64'd0);
`else
        chk("err_data_valid", 64'(rd_data_valid), 64'd1);
        chk("err_data", rd_data, 64'h0000_0000_0000_ABCD);
        chk("err_retry_tied", 64'(intf_pkt_retry), 64'd0);
        chk("err_intf_pkt_tied", 64'(intf_pkt), 64'd0);
        tick();
`endif

        // Orphan return
        phy_rd_valid = 1'b1;
        phy_rd_data  = 64'h1234;
        tick();
        phy_rd_valid = 1'b0;
        chk("orphan_no_data", 64'(rd_data_valid), 64'd0);
        chk("orphan_stat", 64'(stat), 64'd3);

        // Timeout: RD issued at edge E0, flag must appear exactly at E255
        set_push(1'b1, 16'd7, CMD_RD);
        tick();
        set_push(1'b0, 16'd0, CMD_NOP1);
        tick();
        repeat (254) tick();
        chk("to_before", 64'(stat[2]), 64'd0);
        tick();
        chk("to_at", 64'(stat[2]), 64'd1);

        // Reset with a tag outstanding; later return is an orphan
        rst = 1'b0;
        tick();
        chk("mid_rst_stat", 64'(stat), 64'd0);
        chk("mid_rst_rdy", 64'(intf_rdy), 64'd0);
        rst = 1'b1;
        tick();
        chk("mid_rel_rdy", 64'(intf_rdy), 64'd1);
        phy_rd_valid = 1'b1;
        tick();
        phy_rd_valid = 1'b0;
        chk("mid_orphan_stat", 64'(stat), 64'd2);
        chk("mid_orphan_nodata", 64'(rd_data_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
